// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receive and transmit paths.
package rs232_pkg;
   localparam int OVERSAMPLE = 16;
   localparam int HALF_BIT   = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rs232_state_e;
endpackage

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, phase reset by reload.
module rs232_baud_tick #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic reload,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= LOAD_VAL;
      end else if (reload || (cnt_q == '0)) begin
         cnt_q <= LOAD_VAL;
      end else begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign tick = (cnt_q == '0);
endmodule

// File: rtl/rs232_rx_word.sv
// 8N1 receiver with 16x oversampling; assembles WORD_BYTES bytes, LSB byte first, into one word.
//
//   state        | meaning
//   ST_IDLE      | line idle, waiting for a falling edge; runs the inter-byte gap timer
//   ST_START     | half a bit into the start bit, confirm it is still low
//   ST_DATA      | sample 8 data bits at mid-bit, LSB first
//   ST_STOP      | sample the stop bit, store byte or flag a framing error
//   ST_WAIT_HIGH | after a framing error, wait for 16 consecutive high ticks
module rs232_rx_word
   import rs232_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int WORD_BYTES = 3,
   parameter int GAP_BITS   = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    RxD,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    word_valid,
   output logic                    frame_err,
   output logic                    busy
);
   localparam int DIV       = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int WW        = 8 * WORD_BYTES;
   localparam int TW        = $clog2(OVERSAMPLE);
   localparam int IW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int GAP_TICKS = GAP_BITS * OVERSAMPLE;
   localparam int GW        = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_BIT - 1);
   localparam logic [TW-1:0] BIT_LOAD  = TW'(OVERSAMPLE - 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(WORD_BYTES - 1);

   rs232_state_e  state_q, state_d;
   logic [1:0]    sync_q;
   logic          rxd_s;
   logic          tick;
   logic          start_det;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [WW-1:0] acc_q, acc_d;
   logic [IW-1:0] byte_idx_q, byte_idx_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [WW-1:0] word_q, word_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;

   assign rxd_s = sync_q[1];
   // Tick phase restarts on the start edge so mid-bit samples land where expected.
   assign start_det = (state_q == ST_IDLE) && !rxd_s;

   rs232_baud_tick #(.DIV(DIV)) u_baud_tick (
      .clk    (clk),
      .reset  (reset),
      .reload (start_det),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sync_q     <= 2'b11;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         acc_q      <= '0;
         byte_idx_q <= '0;
         gap_cnt_q  <= GAP_LOAD;
         word_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[0], RxD};
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         acc_q      <= acc_d;
         byte_idx_q <= byte_idx_d;
         gap_cnt_q  <= gap_cnt_d;
         word_q     <= word_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      acc_d      = acc_q;
      byte_idx_d = byte_idx_q;
      gap_cnt_d  = GAP_LOAD;
      word_d     = word_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_det) begin
               state_d    = ST_START;
               tick_cnt_d = HALF_LOAD;
            end else if (byte_idx_q != '0) begin
               gap_cnt_d = gap_cnt_q;
               if (tick) begin
                  if (gap_cnt_q == '0) begin
                     byte_idx_d = '0;
                     gap_cnt_d  = GAP_LOAD;
                  end else begin
                     gap_cnt_d = gap_cnt_q - GW'(1);
                  end
               end
            end
         end

         ST_START: begin
            if (tick) begin
               if (tick_cnt_q != '0) begin
                  tick_cnt_d = tick_cnt_q - TW'(1);
               end else if (rxd_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_DATA;
                  tick_cnt_d = BIT_LOAD;
                  bit_cnt_d  = '0;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (tick_cnt_q != '0) begin
                  tick_cnt_d = tick_cnt_q - TW'(1);
               end else begin
                  shreg_d    = {rxd_s, shreg_q[7:1]};
                  tick_cnt_d = BIT_LOAD;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               if (tick_cnt_q != '0) begin
                  tick_cnt_d = tick_cnt_q - TW'(1);
               end else if (rxd_s) begin
                  for (int k = 0; k < WORD_BYTES; k++) begin
                     if (byte_idx_q == IW'(k)) acc_d[8*k +: 8] = shreg_q;
                  end
                  if (byte_idx_q == LAST_IDX) begin
                     word_d     = acc_d;
                     valid_d    = 1'b1;
                     byte_idx_d = '0;
                  end else begin
                     byte_idx_d = byte_idx_q + IW'(1);
                  end
                  state_d = ST_IDLE;
               end else begin
                  ferr_d     = 1'b1;
                  byte_idx_d = '0;
                  tick_cnt_d = BIT_LOAD;
                  state_d    = ST_WAIT_HIGH;
               end
            end
         end

         ST_WAIT_HIGH: begin
            // Any low sample restarts the 16-tick high window.
            if (!rxd_s) begin
               tick_cnt_d = BIT_LOAD;
            end else if (tick) begin
               if (tick_cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q - TW'(1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign frame_err  = ferr_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_rs232_rx_word.sv
// Directed bench for rs232_rx_word: byte-level model of expected words and framing errors.
module tb_rs232_rx_word;
   localparam int WB       = 3;
   localparam int BT       = 160;
   localparam int GAP_BITS = 20;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        RxD   = 1'b1;
   logic [23:0] word_out;
   logic        word_valid;
   logic        frame_err;
   logic        busy;

   rs232_rx_word #(
      .CLK_HZ     (1_600_000),
      .BAUD       (10_000),
      .WORD_BYTES (WB),
      .GAP_BITS   (GAP_BITS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .RxD        (RxD),
      .word_out   (word_out),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [23:0] exp_words[$];
   int          rd_idx = 0;
   logic [7:0]  partial[$];
   int          ferr_expected = 0;
   int          n_ferr = 0;
   int          n_valid = 0;
   int          busy_rises = 0;
   logic [23:0] held_word = '0;
   logic        prev_valid = 1'b0;
   logic        prev_busy = 1'b0;
   logic        timed_out = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   function automatic logic [23:0] pack_partial();
      logic [23:0] w = '0;
      for (int k = 0; k < WB; k++) w = w | (24'(partial[k]) << (8 * k));
      return w;
   endfunction

   // Model update happens before the frame goes out, so the expectation exists when the strobe arrives.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bt);
      if (stop) begin
         partial.push_back(b);
         if (partial.size() == WB) begin
            exp_words.push_back(pack_partial());
            partial.delete();
         end
      end else begin
         ferr_expected++;
         partial.delete();
      end
      RxD = 1'b0;
      wait_clk(bt);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         wait_clk(bt);
      end
      RxD = stop;
      wait_clk(bt);
   endtask

   task automatic idle_bits(input int n, input int bt);
      RxD = 1'b1;
      wait_clk(n * bt);
      if (n > GAP_BITS) partial.delete();
   endtask

   task automatic send_word(input logic [23:0] w, input int bt);
      for (int k = 0; k < WB; k++) begin
         send_frame(w[8*k +: 8], 1'b1, bt);
         idle_bits(1, bt);
      end
      idle_bits(1, bt);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (reset) begin
            held_word = '0;
            check("reset_word_out", 32'(word_out), 32'h0);
            check("reset_word_valid", 32'(word_valid), 32'h0);
            check("reset_frame_err", 32'(frame_err), 32'h0);
            check("reset_busy", 32'(busy), 32'h0);
         end else begin
            check("valid_ferr_exclusive", 32'(word_valid & frame_err), 32'h0);
            check("valid_one_cycle", 32'(word_valid & prev_valid), 32'h0);
            if (word_valid) begin
               n_valid++;
               if (rd_idx >= exp_words.size()) begin
                  check("word_valid_expected", 32'(word_valid), 32'h0);
               end else begin
                  check("word_out", 32'(word_out), 32'(exp_words[rd_idx]));
                  held_word = exp_words[rd_idx];
                  rd_idx++;
               end
            end else begin
               check("word_out_hold", 32'(word_out), 32'(held_word));
            end
            if (frame_err) begin
               if (n_ferr >= ferr_expected) check("frame_err_expected", 32'(frame_err), 32'h0);
               n_ferr++;
            end
         end
         if (busy && !prev_busy) busy_rises++;
         prev_valid = word_valid;
         prev_busy  = busy;
      end
   endtask

   task automatic stimulus();
      int v0, f0, b0;

      wait_clk(4);
      #1;
      check("init_word_out", 32'(word_out), 32'h0);
      check("init_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      idle_bits(3, BT);
      check("init_no_busy", 32'(busy_rises), 32'h0);

      // Ideal timing, then +/-2.5% bit rate.
      v0 = n_valid; f0 = n_ferr;
      send_word(24'h003039, BT);
      check("ideal_word", 32'(word_out), 32'h003039);
      check("ideal_valid_cnt", 32'(n_valid - v0), 32'd1);
      check("ideal_ferr_cnt", 32'(n_ferr - f0), 32'd0);
      v0 = n_valid;
      send_word(24'h003039, 164);
      check("slow_word", 32'(word_out), 32'h003039);
      check("slow_valid_cnt", 32'(n_valid - v0), 32'd1);
      v0 = n_valid;
      send_word(24'h003039, 156);
      check("fast_word", 32'(word_out), 32'h003039);
      check("fast_valid_cnt", 32'(n_valid - v0), 32'd1);

      // Short low glitch.
      v0 = n_valid; f0 = n_ferr; b0 = busy_rises;
      RxD = 1'b0;
      wait_clk(40);
      idle_bits(2, BT);
      check("glitch_busy_pulse", 32'(busy_rises - b0), 32'd1);
      check("glitch_busy_low", 32'(busy), 32'h0);
      check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
      check("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);

      // Framing error followed by a held-low line, then a clean word.
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h55, 1'b0, BT);
      wait_clk(3 * BT);
      idle_bits(2, BT);
      send_word(24'h030201, BT);
      check("ferr_cnt", 32'(n_ferr - f0), 32'd1);
      check("ferr_word", 32'(word_out), 32'h030201);
      check("ferr_valid_cnt", 32'(n_valid - v0), 32'd1);

      // Partial word dropped after a long idle gap.
      v0 = n_valid;
      send_frame(8'hAA, 1'b1, BT);
      idle_bits(1, BT);
      send_frame(8'hBB, 1'b1, BT);
      idle_bits(25, BT);
      check("gap_no_valid", 32'(n_valid - v0), 32'd0);
      send_word(24'h332211, BT);
      check("gap_word", 32'(word_out), 32'h332211);
      check("gap_valid_cnt", 32'(n_valid - v0), 32'd1);

      // Reset during the data bits of the second byte.
      v0 = n_valid;
      send_frame(8'hEE, 1'b1, BT);
      idle_bits(1, BT);
      RxD = 1'b0;
      wait_clk(4 * BT);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      partial.delete();
      check("rst_word_out", 32'(word_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_valid", 32'(word_valid), 32'h0);
      wait_clk(3);
      #1 reset = 1'b0;
      idle_bits(2, BT);
      check("rst_hold_zero", 32'(word_out), 32'h0);
      send_word(24'h030201, BT);
      check("rst_word", 32'(word_out), 32'h030201);
      check("rst_valid_cnt", 32'(n_valid - v0), 32'd1);

      check("all_words_seen", 32'(exp_words.size() - rd_idx), 32'd0);
      check("all_ferr_seen", 32'(n_ferr), 32'(ferr_expected));
   endtask

   initial begin
      fork
         monitor();
      join_none
      fork
         stimulus();
         begin
            wait_clk(95000);
            timed_out = 1'b1;
         end
      join_any
      disable fork;
      check("watchdog", 32'(timed_out), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
